// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive-side controller.
//   BITS_PER_CHAR : bit-times in one character (start + 8 data + stop)
//   GUARD_BITS    : bit-times a reception may last before busy is abandoned
//   INTR_*        : bit positions within the write-1-to-clear interrupt vector
//   busy_state_e  : receiver busy tracker states
package uart_pkg;

    localparam int unsigned BITS_PER_CHAR = 10;
    localparam int unsigned GUARD_BITS    = 11;

    localparam int unsigned INTR_TIMEOUT  = 0;
    localparam int unsigned INTR_OVF      = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } busy_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointers/level only)
//   push_i        : write wdata_i; accepted when not full or when a pop is accepted
//   pop_i         : consume head; ignored while empty
//   clr_i         : flush, wins over push and pop in the same cycle
//   rdata_o       : registered head byte, valid when valid_o = 1
//   valid_o       : FIFO not empty
//   level_o       : occupancy 0..DEPTH
//   full_o        : level_o == DEPTH
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clr_i,
    input  logic [DW-1:0]          wdata_i,
    output logic [DW-1:0]          rdata_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d;
    logic          pop_ok;
    logic          push_ok;

    // Pointer, level and registered-head next state.
    always_comb begin
        pop_ok  = pop_i & valid_q;
        push_ok = push_i & (~full_q | pop_ok);

        wptr_d  = wptr_q + AW'(push_ok);
        rptr_d  = rptr_q + AW'(pop_ok);
        level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        rdata_d = rdata_q;

        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            rdata_d = '0;
        end else if (level_d != '0) begin
            // The incoming byte becomes the head when it lands at the new read slot.
            rdata_d = (push_ok && (rptr_d == wptr_q)) ? wdata_i : mem_q[rptr_d];
        end

        valid_d = (level_d != '0);
        full_d  = (level_d == (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            full_q  <= full_d;
        end
    end

    // Storage is not reset; only positions covered by level are ever read.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;
    assign valid_o = valid_q;
    assign level_o = level_q;
    assign full_o  = full_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller between the register block and the uart_rx receiver.
// Applies enable/baud configuration only while the receiver is idle, buffers
// received bytes in a FWFT FIFO and raises threshold, timeout and overflow
// interrupts.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   rx_en_i                : requested receiver enable
//   clks_per_bit_i         : requested baud divisor
//   thresh_i               : FIFO level threshold, 0 disables
//   timeout_chars_i        : idle character-times before timeout, 0 disables
//   fifo_clr_i             : FIFO flush pulse
//   pop_i                  : consume head byte
//   intr_clr_i             : W1C, [0] timeout, [1] overflow
//   rx_data_i, rx_done_i   : received byte and its strobe
//   rx_start_i             : receiver start-bit indication
//   rx_en_o, clks_per_bit_o: configuration applied to the receiver
//   rdata_o, rvalid_o      : head byte and FIFO-not-empty
//   level_o                : FIFO occupancy
//   intr_*_o               : interrupt outputs
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter logic [15:0] CPB_RST = 16'd868
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_en_i,
    input  logic [15:0]            clks_per_bit_i,
    input  logic [$clog2(DEPTH):0] thresh_i,
    input  logic [7:0]             timeout_chars_i,
    input  logic                   fifo_clr_i,
    input  logic                   pop_i,
    input  logic [1:0]             intr_clr_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_done_i,
    input  logic                   rx_start_i,
    output logic                   rx_en_o,
    output logic [15:0]            clks_per_bit_o,
    output logic [7:0]             rdata_o,
    output logic                   rvalid_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   intr_thresh_o,
    output logic                   intr_timeout_o,
    output logic                   intr_ovf_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 16;  // baud divisor / bit-clock counter width
    localparam int unsigned BW = 12;  // bit-time counter width
    localparam int unsigned GW = 20;  // guard counter width, covers 11 * 65535

    busy_state_e   state_q, state_d;
    logic          start_q, start_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [CW-1:0] cpb_q, cpb_d;
    logic          rx_en_q, rx_en_d;
    logic [CW-1:0] bclk_q, bclk_d;
    logic [BW-1:0] btime_q, btime_d;
    logic          to_hold_q, to_hold_d;
    logic          thresh_q, thresh_d;
    logic          timeout_q, timeout_d;
    logic          ovf_q, ovf_d;

    logic          fifo_full;
    logic          push_req;
    logic          pop_ok;
    logic          push_ok;
    logic          start_rise;
    logic          busy_entry;
    logic [GW-1:0] guard_limit;
    logic          guard_last;
    logic [BW-1:0] btime_limit;
    logic          bclk_last;
    logic          btime_last;
    logic          to_clear;
    logic          to_run;
    logic          timeout_set;
    logic          ovf_set;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_req),
        .pop_i   (pop_i),
        .clr_i   (fifo_clr_i),
        .wdata_i (rx_data_i),
        .rdata_o (rdata_o),
        .valid_o (rvalid_o),
        .level_o (level_o),
        .full_o  (fifo_full)
    );

    // Next-state logic for busy tracking, configuration, timeout and interrupts.
    always_comb begin
        state_d     = state_q;
        start_d     = rx_start_i;
        guard_d     = guard_q;
        cpb_d       = cpb_q;
        rx_en_d     = rx_en_q;
        bclk_d      = bclk_q;
        btime_d     = btime_q;
        to_hold_d   = to_hold_q;
        timeout_set = 1'b0;

        // Mirror the FIFO's accept rules so overflow and timeout clears agree with it.
        push_req = rx_done_i & rx_en_q;
        pop_ok   = pop_i & rvalid_o;
        push_ok  = push_req & (~fifo_full | pop_ok);
        ovf_set  = push_req & fifo_full & ~pop_ok;

        start_rise  = rx_start_i & ~start_q;
        busy_entry  = (state_q == ST_IDLE) & start_rise;
        guard_limit = GW'(cpb_q) * GW'(GUARD_BITS);
        guard_last  = (guard_q + GW'(1)) >= guard_limit;

        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_BUSY;
                    guard_d = '0;
                end
            end
            ST_BUSY: begin
                // Guard expiry recovers from a false start that never completes.
                if (rx_done_i || guard_last) begin
                    state_d = ST_IDLE;
                    guard_d = '0;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                guard_d = '0;
            end
        endcase

        // Configuration follows the request only while idle; disable is always honoured.
        if (state_q == ST_IDLE) begin
            cpb_d = clks_per_bit_i;
        end
        rx_en_d = rx_en_i & ((state_q == ST_IDLE) | rx_en_q);

        // Character timeout: bit-clock prescaler feeding a bit-time counter.
        btime_limit = BW'(BITS_PER_CHAR) * BW'(timeout_chars_i);
        bclk_last   = ((CW+1)'(bclk_q) + (CW+1)'(1)) >= (CW+1)'(cpb_q);
        btime_last  = ((BW+1)'(btime_q) + (BW+1)'(1)) >= (BW+1)'(btime_limit);
        to_clear    = push_ok | pop_ok | fifo_clr_i | busy_entry;
        to_run      = rvalid_o & (state_q == ST_IDLE) & (timeout_chars_i != '0) & ~to_hold_q;

        if (to_clear) begin
            bclk_d    = '0;
            btime_d   = '0;
            to_hold_d = 1'b0;
        end else if (to_run) begin
            if (!bclk_last) begin
                bclk_d = bclk_q + CW'(1);
            end else if (!btime_last) begin
                bclk_d  = '0;
                btime_d = btime_q + BW'(1);
            end else begin
                // Terminal count: freeze until the next clear event.
                to_hold_d   = 1'b1;
                timeout_set = 1'b1;
            end
        end

        thresh_d  = (thresh_i != '0) && (level_o >= thresh_i);
        // Set beats a simultaneous write-1-to-clear.
        timeout_d = timeout_set | (timeout_q & ~intr_clr_i[INTR_TIMEOUT]);
        ovf_d     = ovf_set | (ovf_q & ~intr_clr_i[INTR_OVF]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            guard_q   <= '0;
            cpb_q     <= CPB_RST;
            rx_en_q   <= 1'b0;
            bclk_q    <= '0;
            btime_q   <= '0;
            to_hold_q <= 1'b0;
            thresh_q  <= 1'b0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            guard_q   <= guard_d;
            cpb_q     <= cpb_d;
            rx_en_q   <= rx_en_d;
            bclk_q    <= bclk_d;
            btime_q   <= btime_d;
            to_hold_q <= to_hold_d;
            thresh_q  <= thresh_d;
            timeout_q <= timeout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rx_en_o        = rx_en_q;
    assign clks_per_bit_o = cpb_q;
    assign intr_thresh_o  = thresh_q;
    assign intr_timeout_o = timeout_q;
    assign intr_ovf_o     = ovf_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table-driven FIFO/threshold vectors,
// scoreboarded byte order, and hand sequences for timeout, busy and reset.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk_i;
    logic          rst_ni;
    logic          rx_en_i;
    logic [15:0]   clks_per_bit_i;
    logic [AW:0]   thresh_i;
    logic [7:0]    timeout_chars_i;
    logic          fifo_clr_i;
    logic          pop_i;
    logic [1:0]    intr_clr_i;
    logic [7:0]    rx_data_i;
    logic          rx_done_i;
    logic          rx_start_i;
    logic          rx_en_o;
    logic [15:0]   clks_per_bit_o;
    logic [7:0]    rdata_o;
    logic          rvalid_o;
    logic [AW:0]   level_o;
    logic          intr_thresh_o;
    logic          intr_timeout_o;
    logic          intr_ovf_o;

    uart_rx_ctrl #(
        .DEPTH   (DEPTH),
        .CPB_RST (16'd868)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .rx_en_i         (rx_en_i),
        .clks_per_bit_i  (clks_per_bit_i),
        .thresh_i        (thresh_i),
        .timeout_chars_i (timeout_chars_i),
        .fifo_clr_i      (fifo_clr_i),
        .pop_i           (pop_i),
        .intr_clr_i      (intr_clr_i),
        .rx_data_i       (rx_data_i),
        .rx_done_i       (rx_done_i),
        .rx_start_i      (rx_start_i),
        .rx_en_o         (rx_en_o),
        .clks_per_bit_o  (clks_per_bit_o),
        .rdata_o         (rdata_o),
        .rvalid_o        (rvalid_o),
        .level_o         (level_o),
        .intr_thresh_o   (intr_thresh_o),
        .intr_timeout_o  (intr_timeout_o),
        .intr_ovf_o      (intr_ovf_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        push;
        logic [7:0]  data;
        logic        pop;
        logic [AW:0] exp_level;
        logic        exp_thresh;
    } vec_t;

    vec_t       vecs [14];
    logic [7:0] sb_q [$];
    int         n_checks;
    int         n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the active edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data_i = b;
        rx_done_i = 1'b1;
        step();
        rx_done_i = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] e;
        check({name, "_rvalid"}, 32'(rvalid_o), 32'd1);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, rdata 0x%0h", name, rdata_o);
        end else begin
            e = sb_q.pop_front();
            check(name, 32'(rdata_o), 32'(e));
        end
        pop_i = 1'b1;
        step();
        pop_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rx_en"},   32'(rx_en_o),        32'd0);
        check({tag, "_cpb"},     32'(clks_per_bit_o), 32'd868);
        check({tag, "_rvalid"},  32'(rvalid_o),       32'd0);
        check({tag, "_level"},   32'(level_o),        32'd0);
        check({tag, "_rdata"},   32'(rdata_o),        32'd0);
        check({tag, "_thresh"},  32'(intr_thresh_o),  32'd0);
        check({tag, "_timeout"}, 32'(intr_timeout_o), 32'd0);
        check({tag, "_ovf"},     32'(intr_ovf_o),     32'd0);
    endtask

    initial begin
        logic [7:0] e;
        logic       accept;
        int         n;

        n_checks = 0;
        n_fail   = 0;

        // {push, data, pop, level after edge, threshold flag after edge} with thresh_i = 4
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b0};
        vecs[1]  = '{1'b1, 8'h12, 1'b0, 5'd2, 1'b0};
        vecs[2]  = '{1'b1, 8'h13, 1'b0, 5'd3, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 5'd3, 1'b0};
        vecs[4]  = '{1'b1, 8'h14, 1'b0, 5'd4, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 5'd4, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 5'd3, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 5'd3, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0};
        vecs[12] = '{1'b1, 8'h55, 1'b1, 5'd1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0};

        rst_ni          = 1'b0;
        rx_en_i         = 1'b0;
        clks_per_bit_i  = 16'd868;
        thresh_i        = '0;
        timeout_chars_i = 8'd0;
        fifo_clr_i      = 1'b0;
        pop_i           = 1'b0;
        intr_clr_i      = 2'b00;
        rx_data_i       = 8'h00;
        rx_done_i       = 1'b0;
        rx_start_i      = 1'b0;

        step();
        step();
        check_reset("reset");
        rst_ni  = 1'b1;
        rx_en_i = 1'b1;
        step();
        step();
        check("rx_en_apply", 32'(rx_en_o), 32'd1);

        // FIFO ordering, empty pop, push into empty with pop, threshold lag.
        thresh_i = 5'd4;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].pop && rvalid_o) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL vec%0d_data: scoreboard empty, rdata 0x%0h", i, rdata_o);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("vec%0d_data", i), 32'(rdata_o), 32'(e));
                end
            end
            accept = vecs[i].push && ((level_o < 5'(DEPTH)) || (vecs[i].pop && rvalid_o));
            if (accept) sb_q.push_back(vecs[i].data);
            rx_data_i = vecs[i].data;
            rx_done_i = vecs[i].push;
            pop_i     = vecs[i].pop;
            step();
            rx_done_i = 1'b0;
            pop_i     = 1'b0;
            check($sformatf("vec%0d_level", i),  32'(level_o),       32'(vecs[i].exp_level));
            check($sformatf("vec%0d_rvalid", i), 32'(rvalid_o),      32'(vecs[i].exp_level != '0));
            check($sformatf("vec%0d_thresh", i), 32'(intr_thresh_o), 32'(vecs[i].exp_thresh));
        end
        thresh_i = '0;

        // Overflow: 17th byte dropped; overflow set wins over a same-cycle clear.
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(8'hA0 + 8'(i));
            rx_byte(8'hA0 + 8'(i));
        end
        intr_clr_i = 2'b10;
        rx_byte(8'hAF + 8'd1);
        intr_clr_i = 2'b00;
        check("ovf_level", 32'(level_o), 32'd16);
        check("ovf_set_wins", 32'(intr_ovf_o), 32'd1);
        for (int i = 0; i < 16; i++) pop_check($sformatf("ovf_drain%0d", i));
        check("ovf_17th_absent", 32'(rvalid_o), 32'd0);
        intr_clr_i = 2'b10;
        step();
        intr_clr_i = 2'b00;
        check("ovf_clear", 32'(intr_ovf_o), 32'd0);

        // Full with coincident pop: both happen, no overflow.
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(8'hB0 + 8'(i));
            rx_byte(8'hB0 + 8'(i));
        end
        e = sb_q.pop_front();
        check("full_pop_head", 32'(rdata_o), 32'(e));
        sb_q.push_back(8'hC0);
        pop_i = 1'b1;
        rx_byte(8'hC0);
        pop_i = 1'b0;
        check("full_pop_level", 32'(level_o), 32'd16);
        check("full_pop_no_ovf", 32'(intr_ovf_o), 32'd0);
        for (int i = 0; i < 16; i++) pop_check($sformatf("full_drain%0d", i));
        check("full_drain_empty", 32'(level_o), 32'd0);

        // Flush beats a coincident push.
        rx_byte(8'h01);
        rx_byte(8'h02);
        fifo_clr_i = 1'b1;
        rx_byte(8'h03);
        fifo_clr_i = 1'b0;
        check("clr_level", 32'(level_o), 32'd0);
        check("clr_rvalid", 32'(rvalid_o), 32'd0);

        // Character timeout: 2 chars * 10 bits * 8 clocks = 160 idle clocks.
        clks_per_bit_i  = 16'd8;
        timeout_chars_i = 8'd2;
        step();
        step();
        check("cpb_8", 32'(clks_per_bit_o), 32'd8);
        sb_q.push_back(8'h77);
        rx_byte(8'h77);
        n = 0;
        while (n < 300 && !intr_timeout_o) begin
            step();
            n++;
        end
        check("timeout_clocks", 32'(n), 32'd160);
        intr_clr_i = 2'b01;
        step();
        intr_clr_i = 2'b00;
        check("timeout_clear", 32'(intr_timeout_o), 32'd0);
        repeat (200) step();
        check("timeout_hold", 32'(intr_timeout_o), 32'd0);
        pop_check("timeout_byte");
        timeout_chars_i = 8'd0;

        // Configuration held while busy; disable forced; reload after rx_done_i.
        clks_per_bit_i = 16'd868;
        step();
        step();
        check("cpb_868", 32'(clks_per_bit_o), 32'd868);
        rx_start_i = 1'b1;
        step();
        rx_start_i     = 1'b0;
        clks_per_bit_i = 16'd434;
        repeat (20) step();
        check("busy_cpb_hold", 32'(clks_per_bit_o), 32'd868);
        rx_en_i = 1'b0;
        step();
        check("busy_force_dis", 32'(rx_en_o), 32'd0);
        rx_en_i = 1'b1;
        step();
        check("busy_en_hold", 32'(rx_en_o), 32'd0);
        rx_byte(8'h5A);
        check("done_cpb_868", 32'(clks_per_bit_o), 32'd868);
        step();
        check("idle_cpb_434", 32'(clks_per_bit_o), 32'd434);
        check("idle_rx_en", 32'(rx_en_o), 32'd1);
        check("disabled_drop", 32'(level_o), 32'd0);

        // False start: guard releases busy after 11 * 8 clocks, config loads a cycle later.
        clks_per_bit_i = 16'd8;
        step();
        step();
        check("guard_cpb_8", 32'(clks_per_bit_o), 32'd8);
        rx_start_i = 1'b1;
        step();
        rx_start_i     = 1'b0;
        clks_per_bit_i = 16'd12;
        n = 0;
        while (n < 200 && clks_per_bit_o != 16'd12) begin
            step();
            n++;
        end
        check("guard_clocks", 32'(n), 32'd89);

        // Asynchronous reset in the middle of a reception.
        thresh_i = 5'd1;
        rx_byte(8'h33);
        step();
        check("pre_rst_thresh", 32'(intr_thresh_o), 32'd1);
        rx_start_i = 1'b1;
        step();
        rx_start_i = 1'b0;
        repeat (5) step();
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset("async_rst");
        sb_q.delete();
        step();
        rst_ni = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller that sits between the bus register block and the uart_rx serial receiver. It safely applies rx enable and baud configuration, and captures each received byte into a first-word-fall-through FIFO. It also raises threshold, character-timeout and overflow interrupts. Software drains bytes through a pop handshake.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2; AW = $clog2(DEPTH)
CPB_RST, 16'd868, clks_per_bit_o value applied at reset

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
rx_en_i  in  1  requested receiver enable, from register block
clks_per_bit_i  in  16  requested clocks per bit
thresh_i  in  AW+1  FIFO level threshold; 0 disables the threshold interrupt
timeout_chars_i  in  8  idle character-times before timeout; 0 disables the timeout
fifo_clr_i  in  1  synchronous FIFO flush, one-cycle pulse
pop_i  in  1  consume the head byte
intr_clr_i  in  2  write-1-to-clear; bit0 = timeout, bit1 = overflow
rx_data_i  in  8  byte from receiver
rx_done_i  in  1  one-cycle pulse: rx_data_i is valid
rx_start_i  in  1  receiver start-bit indication
rx_en_o  out  1  enable applied to receiver
clks_per_bit_o  out  16  baud divisor applied to receiver
rdata_o  out  8  head byte; valid when rvalid_o = 1
rvalid_o  out  1  FIFO not empty
level_o  out  AW+1  FIFO occupancy, 0..DEPTH
intr_thresh_o  out  1  level_o >= thresh_i and thresh_i != 0
intr_timeout_o  out  1  sticky character-timeout flag
intr_ovf_o  out  1  sticky overflow flag

Behaviour:
- Reset values: rx_en_o = 0, clks_per_bit_o = CPB_RST, rvalid_o = 0, level_o = 0, rdata_o = 0, all interrupts 0, busy = 0, all counters 0.
- Busy tracker (states IDLE, BUSY):
  - IDLE -> BUSY on a rising edge of rx_start_i. The previous value of rx_start_i is registered for edge detection.
  - BUSY -> IDLE on rx_done_i, or when the guard counter reaches 11 * clks_per_bit_o clocks. The guard counter covers a false start that never produces rx_done_i.
- Configuration: clks_per_bit_o and rx_en_o load from their inputs only in IDLE, one cycle after the input changes. In BUSY the outputs hold their values.
  - Exception: rx_en_i = 0 forces rx_en_o = 0 on the next cycle regardless of state.
- Push: occurs on rx_done_i when rx_en_o = 1.
  - Not full: the byte is written at wptr.
  - Full and no pop in the same cycle: the byte is dropped and intr_ovf_o is set.
  - Full with pop in the same cycle: both are performed, level stays DEPTH, no overflow.
- Pop: occurs on pop_i when rvalid_o = 1. pop_i while empty is ignored with no state change.
  - FWFT: rdata_o = mem[rptr] combinationally, or registered with zero added latency.
  - Pointers are AW bits wide and wrap modulo DEPTH.
- Level: level_o = level_o + push - pop each cycle; it never exceeds DEPTH and never underflows.
- fifo_clr_i: sets pointers and level to 0, clears the timeout counters, and takes priority over a push or pop in the same cycle. Sticky flags are not affected.
- Threshold interrupt: a registered compare, updated one cycle after any level change.
- Timeout counting (two-stage):
  - Bit-clock counter runs 0..clks_per_bit_o-1.
  - Bit-time counter runs 0..10*timeout_chars_i-1, 12 bits wide.
  - Counting advances only when level_o != 0, busy = 0 and timeout_chars_i != 0.
  - Both counters clear on push, pop, fifo_clr_i or BUSY entry.
  - On reaching the terminal count, intr_timeout_o is set and the counters hold until the next clear event.
- Sticky flags: a set and an intr_clr_i bit in the same cycle resolve to set.
- Asynchronous reset mid-reception returns every register to its reset value. FIFO contents need not be reset; only the pointers and level are.

Decomposition:
- Package uart_pkg holds:
  - bit-times-per-character constant (10);
  - guard bit-times constant (11);
  - busy-state enum;
  - interrupt index localparams (TIMEOUT = 0, OVF = 1).
- One sub-module, uart_rx_fifo, parameterized by DEPTH and 8-bit width, handles push, pop, clr, rdata, level, full and empty. The controller holds the busy FSM, config latching, timeout counters and interrupts.

Test Plan:
1. Push bytes 0x11..0x14 with rx_done_i pulses -> level_o = 4 and rdata_o = 0x11. Pop four times -> data 0x11, 0x12, 0x13, 0x14 in order, then rvalid_o = 0.
2. Push DEPTH+1 bytes with no pop -> level_o = 16, intr_ovf_o = 1, the 17th byte is absent. Repeat with pop coincident with the 17th push -> no overflow and the 17th byte is retained.
3. Set thresh_i = 4 and push 3 bytes -> intr_thresh_o = 0. Push the 4th byte -> intr_thresh_o = 1 one cycle later. Pop one -> intr_thresh_o = 0.
4. Set clks_per_bit_i = 8 and timeout_chars_i = 2, push 1 byte -> intr_timeout_o rises after 160 idle clocks. Pulse intr_clr_i[0] -> the flag clears.
5. Pulse rx_start_i, then change clks_per_bit_i from 868 to 434 mid-byte -> clks_per_bit_o stays 868 until rx_done_i, then becomes 434.
6. Pulse rx_start_i with no rx_done_i and clks_per_bit_o = 8 -> busy clears after 88 clocks. Assert rst_ni low mid-sequence -> all outputs return to their reset values.
